// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester result-path arbiter.
//   arb_state_t : output register occupancy (EMPTY / FULL)
//   ARB_REQS    : number of requesters sharing the output path
package arb_pkg;

    localparam int ARB_REQS = 2;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_arb_2.sv
// Combinational two-way grant selector.
//   in_valid [1:0] : request lines
//   last_gnt       : index granted by the most recent transfer
//   en             : a transfer may be accepted this cycle
//   gnt_idx        : selected requester (meaningful when any request is valid)
//   gnt_any        : a grant is issued this cycle (en & any request)
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 win every tie;
// otherwise ties alternate away from last_gnt (round-robin).
module rr_arb_2
    import arb_pkg::*;
(
    input  logic [ARB_REQS-1:0] in_valid,
    input  logic                last_gnt,
    input  logic                en,
    output logic                gnt_idx,
    output logic                gnt_any
);

    // Grant index selection: a lone requester always wins, ties are resolved here.
    always_comb begin
        gnt_idx = 1'b0;
        case (in_valid)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            2'b11:   gnt_idx = 1'b0;
`else
            2'b11:   gnt_idx = ~last_gnt;
`endif
            default: gnt_idx = 1'b0;
        endcase
    end

    // A grant only goes out when the output register can take data.
    always_comb begin
        gnt_any = 1'b0;
        if (en) begin
            gnt_any = |in_valid;
        end else begin
            gnt_any = 1'b0;
        end
    end

endmodule : rr_arb_2

// File: rtl/mux64_2x1_arbiter.sv
// Shares one WIDTH-bit result path between two requesters (e.g. ALU result vs.
// memory load) with valid/ready handshakes and a one-entry output register.
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   in_valid [1:0]       requester i presents in_data[i]
//   in_data  [1:0]       requester data (unpacked array, WIDTH bits each)
//   in_ready [1:0]       requester i's data is taken this cycle (one-hot or zero)
//   out_valid            output register holds a transfer
//   out_data / out_src   registered winning data and the index that produced it
//   out_ready            consumer accepts out_data this cycle
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (req 0 wins ties) in
// rr_arb_2; handshake, latency and states are the same in both builds.
module mux64_2x1_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ARB_REQS-1:0] in_valid,
    input  logic [WIDTH-1:0]    in_data [1:0],
    output logic [ARB_REQS-1:0] in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_src,
    input  logic                out_ready
);

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    logic               last_gnt_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_src_r;
    logic               can_load_s;
    logic               gnt_idx_s;
    logic               fire_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic [ARB_REQS-1:0] in_ready_s;

    // Load is possible when the register is empty or being drained this cycle.
    // reset_n gates it so no requester sees a handshake while reset is held.
    always_comb begin
        can_load_s = 1'b0;
        if (reset_n) begin
            can_load_s = (state_r == ARB_EMPTY) | out_ready;
        end else begin
            can_load_s = 1'b0;
        end
    end

    rr_arb_2 u_rr_arb_2 (
        .in_valid (in_valid),
        .last_gnt (last_gnt_r),
        .en       (can_load_s),
        .gnt_idx  (gnt_idx_s),
        .gnt_any  (fire_s)
    );

    // Ready back to the granted requester only; never depends on in_data.
    always_comb begin
        in_ready_s = 2'b00;
        if (fire_s) begin
            in_ready_s[gnt_idx_s] = 1'b1;
        end else begin
            in_ready_s = 2'b00;
        end
    end

    // WIDTH-bit 2:1 data select driven by the grant index.
    always_comb begin
        sel_data_s = '0;
        if (gnt_idx_s) begin
            sel_data_s = in_data[1];
        end else begin
            sel_data_s = in_data[0];
        end
    end

    // Next-state logic for the output register occupancy.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_EMPTY: begin
                if (fire_s) begin
                    state_nxt_s = ARB_FULL;
                end else begin
                    state_nxt_s = ARB_EMPTY;
                end
            end
            ARB_FULL: begin
                if (fire_s) begin
                    state_nxt_s = ARB_FULL;
                end else if (out_ready) begin
                    state_nxt_s = ARB_EMPTY;
                end else begin
                    state_nxt_s = ARB_FULL;
                end
            end
            default: state_nxt_s = ARB_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ARB_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register and grant history; last_gnt resets to 1 so req 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r <= '0;
            out_src_r  <= 1'b0;
            last_gnt_r <= 1'b1;
        end else if (fire_s) begin
            out_data_r <= sel_data_s;
            out_src_r  <= gnt_idx_s;
            last_gnt_r <= gnt_idx_s;
        end else begin
            out_data_r <= out_data_r;
            out_src_r  <= out_src_r;
            last_gnt_r <= last_gnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ARB_FULL);
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule : mux64_2x1_arbiter

// File: tb/tb_mux64_2x1_arbiter.sv
// Directed, table-driven bench for mux64_2x1_arbiter. Inputs are driven on the
// falling edge; in_ready is sampled 1 ns later, registered outputs 1 ns after
// the following rising edge.
module tb_mux64_2x1_arbiter;

    typedef struct {
        logic [1:0]  iv;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        ordy;
        logic [1:0]  exp_ir;
        logic        exp_ov;
        logic [63:0] exp_od;
        logic        exp_src;
        string       name;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  in_valid;
    logic [63:0] in_data [1:0];
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_src;
    logic        out_ready;

    int n_cmp;
    int n_bad;
    vec_t vecs[$];

    mux64_2x1_arbiter #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] iv, input logic [63:0] d0, input logic [63:0] d1,
                       input logic ordy, input logic [1:0] ir, input logic ov,
                       input logic [63:0] od, input logic src, input string name);
        vec_t v;
        v.iv = iv; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_src = src; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] iv, input logic [63:0] d0, input logic [63:0] d1,
                         input logic ordy);
        in_valid   = iv;
        in_data[0] = d0;
        in_data[1] = d1;
        out_ready  = ordy;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Sequence from reset (last_gnt = 1, EMPTY).
        add(2'b01, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b1, 2'b01, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, "single_req0");
        add(2'b10, 64'h0, 64'hA, 1'b1, 2'b10, 1'b1, 64'hA, 1'b1, "back_to_back");
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++)
            add(2'b11, 64'h10, 64'h11, 1'b1, 2'b01, 1'b1, 64'h10, 1'b0, "contention");
`else
        for (int k = 0; k < 2; k++) begin
            add(2'b11, 64'h10, 64'h11, 1'b1, 2'b01, 1'b1, 64'h10, 1'b0, "contention_a");
            add(2'b11, 64'h10, 64'h11, 1'b1, 2'b10, 1'b1, 64'h11, 1'b1, "contention_b");
        end
`endif
        add(2'b10, 64'h0, 64'h5, 1'b1, 2'b10, 1'b1, 64'h5, 1'b1, "load_req1");
        for (int k = 0; k < 3; k++)
            add(2'b11, 64'h20, 64'h21, 1'b0, 2'b00, 1'b1, 64'h5, 1'b1, "backpressure");
        add(2'b11, 64'h20, 64'h21, 1'b1, 2'b01, 1'b1, 64'h20, 1'b0, "release");
        add(2'b00, 64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 64'h20, 1'b0, "drain");
        add(2'b00, 64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 64'h20, 1'b0, "empty_oready");
`ifdef ARB_FIXED_PRIO_EN
        add(2'b11, 64'h30, 64'h31, 1'b0, 2'b01, 1'b1, 64'h30, 1'b0, "tie_from_empty");
        add(2'b00, 64'h0, 64'h0, 1'b0, 2'b00, 1'b1, 64'h30, 1'b0, "hold_full");
`else
        add(2'b11, 64'h30, 64'h31, 1'b0, 2'b10, 1'b1, 64'h31, 1'b1, "tie_from_empty");
        add(2'b00, 64'h0, 64'h0, 1'b0, 2'b00, 1'b1, 64'h31, 1'b1, "hold_full");
`endif

        // Reset held with both requesters valid.
        reset_n = 1'b0;
        drive(2'b11, 64'h1, 64'h2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("reset_in_ready", {62'd0, in_ready}, 64'd0);
            check("reset_out_valid", {63'd0, out_valid}, 64'd0);
            check("reset_out_data", out_data, 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b00, 64'h0, 64'h0, 1'b0);

        // Table-driven sequence.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].d0, vecs[i].d1, vecs[i].ordy);
            #1;
            check({vecs[i].name, "_in_ready"}, {62'd0, in_ready}, {62'd0, vecs[i].exp_ir});
            @(posedge clk);
            #1;
            check({vecs[i].name, "_out_valid"}, {63'd0, out_valid}, {63'd0, vecs[i].exp_ov});
            check({vecs[i].name, "_out_data"}, out_data, vecs[i].exp_od);
            check({vecs[i].name, "_out_src"}, {63'd0, out_src}, {63'd0, vecs[i].exp_src});
        end

        // Reset mid-op while FULL: takes effect without waiting for a clock edge.
        @(negedge clk);
        drive(2'b00, 64'h0, 64'h0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_out_data", out_data, 64'd0);
        check("midreset_out_src", {63'd0, out_src}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b11, 64'h40, 64'h41, 1'b1);
        #1;
        check("post_reset_tie_in_ready", {62'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("post_reset_tie_src", {63'd0, out_src}, 64'd0);
        check("post_reset_tie_data", out_data, 64'h40);
        @(negedge clk);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux64_2x1_arbiter
